// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier project: FSM state encoding and default operand width.
package mult_pkg;

  localparam int MULT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Start/done handshake and operand/product bus of the sequential multiplier.
interface mult_seq_ctrl_if #(
  parameter int W = mult_pkg::MULT_W
);

  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  modport master (
    output start, a, b,
    input  ready, busy, done, p
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, p
  );

endinterface

// File: rtl/mult_seq_ctrl_add_row.sv
// W-bit ripple-carry adder row built from W full-adder cells.
module add_row #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-add W x W unsigned multiplier sharing one adder row over W cycles.
// Define MULT_SEQ_EARLY_TERM_EN to finish early once the remaining multiplier bits are zero.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic            clk,
  input  logic            rst,
  mult_seq_ctrl_if.slave  bus
);

  localparam int             CW       = $clog2(W + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   addend;
  logic [W-1:0]   sum;
  logic           cout;
  logic [2*W-1:0] step_val;

  // Gating the addend instead of the sum keeps cout at 0 on non-add steps.
  assign addend = acc_q[0] ? a_q : '0;

  add_row #(.W(W)) u_add_row (
    .x    (acc_q[2*W-1:W]),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign step_val = {cout, sum, acc_q[W-1:1]};

`ifdef MULT_SEQ_EARLY_TERM_EN
  logic [W-1:0]   low_mask;
  logic           rest_zero;
  logic [CW-1:0]  sh_amt;
  logic [2*W-1:0] short_val;

  // After cnt shifts the unconsumed multiplier bits sit in acc_q[W-1-cnt:0].
  assign low_mask  = {W{1'b1}} >> cnt_q;
  assign rest_zero = ((acc_q[W-1:0] & low_mask) == '0);
  assign sh_amt    = CW'(W) - cnt_q;
  assign short_val = acc_q >> sh_amt;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          acc_d   = {{W{1'b0}}, bus.b};
          cnt_d   = '0;
          state_d = ST_CALC;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        acc_d = step_val;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          p_d     = step_val;
          state_d = ST_DONE;
        end
`ifdef MULT_SEQ_EARLY_TERM_EN
        if (rest_zero) begin
          acc_d   = short_val;
          p_d     = short_val;
          state_d = ST_DONE;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready = (state_q != ST_CALC);
  assign bus.busy  = (state_q == ST_CALC);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.p     = p_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed handshake cases plus an exhaustive W=4 sweep
// with random bus noise while busy, against a product/latency reference model.
module tb_mult_seq_ctrl;

  localparam int W = mult_pkg::MULT_W;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mult_seq_ctrl_if #(.W(W)) bus ();

  mult_seq_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected one");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Number of CALC cycles an operation takes, from the multiplier value alone.
  function automatic int exp_calc(input int bv);
`ifdef MULT_SEQ_EARLY_TERM_EN
    for (int i = 0; i < W; i++)
      if ((bv >> i) == 0) return i + 1;
    return W;
`else
    return W + 0 * bv;
`endif
  endfunction

  // mode 0: quiet; mode 1: start with a=2,b=2 pulsed in cycle k+2; mode 2: random bus noise while busy.
  task automatic run_op(input int av, input int bv, input int mode);
    int n, busy_n, ready_bad, exp_c;
    bit seen;
    string tag;
    exp_c = exp_calc(bv);
    tag   = $sformatf("a=%0d b=%0d", av, bv);
    bus.start = 1'b1;
    bus.a     = W'(av);
    bus.b     = W'(bv);
    step();
    bus.start = 1'b0;
    n = 0; busy_n = 0; ready_bad = 0; seen = 1'b0;
    while (!seen && n < 4 * W) begin
      n++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.busy === 1'b1) busy_n++;
        if (bus.ready === bus.busy) ready_bad++;
        if (mode == 1) begin
          bus.start = (n == 1);
          if (n == 1) begin
            bus.a = W'(2);
            bus.b = W'(2);
          end
        end else if (mode == 2) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.a     = W'($urandom);
          bus.b     = W'($urandom);
        end
        step();
      end
    end
    bus.start = 1'b0;
    check({"latency ", tag}, n, exp_c + 1);
    check({"busy_cycles ", tag}, busy_n, exp_c);
    check({"ready_vs_busy ", tag}, ready_bad, 0);
    check({"ready_at_done ", tag}, bus.ready, 1);
    check({"product ", tag}, bus.p, av * bv);
  endtask

  initial begin
    int pulses;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    check("reset_p", bus.p, 0);
    check("reset_done", bus.done, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_ready", bus.ready, 1);
    rst = 1'b0;
    step();

    // Basic product, then hold for ten idle cycles.
    run_op(3, 5, 0);
    repeat (10) step();
    check("hold_p", bus.p, 15);
    check("hold_done", bus.done, 0);
    check("hold_ready", bus.ready, 1);

    // Carry path and multiplier-zero / multiplier-one latencies.
    step();
    run_op(15, 15, 0);
    step();
    run_op(9, 0, 0);
    step();
    run_op(9, 1, 0);

    // A start pulsed while busy is ignored.
    step();
    run_op(7, 6, 1);

    // Reset mid-calculation clears the block and suppresses done.
    step();
    bus.start = 1'b1;
    bus.a     = W'(5);
    bus.b     = W'(5);
    step();
    bus.start = 1'b0;
    check("pre_reset_busy", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_reset_busy", bus.busy, 0);
    check("mid_reset_ready", bus.ready, 1);
    check("mid_reset_p", bus.p, 0);
    pulses = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (bus.done === 1'b1) pulses++;
      step();
    end
    check("mid_reset_done_pulses", pulses, 0);
    run_op(2, 3, 0);

    // Back-to-back: the second start arrives in the DONE cycle of the first.
    step();
    run_op(3, 3, 0);
    run_op(4, 4, 0);

    // Exhaustive sweep with random operand/start noise while busy and random idle gaps.
    for (int ai = 0; ai < (1 << W); ai++) begin
      for (int bi = 0; bi < (1 << W); bi++) begin
        if ($urandom_range(0, 1) == 1) step();
        run_op(ai, bi, 2);
      end
    end

    step();
    check("final_done_low", bus.done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
